// File: rtl/pit_pkg.sv
// Shared codes and constants for the 8254-style channel controller.
package pit_pkg;

  localparam int CNT_W  = 16;
  localparam int DATA_W = 8;

  // Read/write access codes carried in control-word bits [5:4]
  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  typedef enum logic [1:0] {
    S_UNPROG   = 2'd0,
    S_WAIT_MSB = 2'd1,
    S_LOAD     = 2'd2,
    S_RUN      = 2'd3
  } state_t;

  // Pick the byte a read returns for the stored access mode and read pointer
  function automatic logic [DATA_W-1:0] sel_byte(input logic [CNT_W-1:0] src,
                                                 input logic [1:0] rw,
                                                 input logic msb_next);
    case (rw)
      RW_LSB:  sel_byte = src[7:0];
      RW_MSB:  sel_byte = src[15:8];
      default: sel_byte = msb_next ? src[15:8] : src[7:0];
    endcase
  endfunction

endpackage

// File: rtl/pit_channel_ctrl_if.sv
// Bus-side strobes and data for one counter channel.
interface pit_channel_ctrl_if;
  import pit_pkg::*;

  logic              ctrl_we;
  logic              data_we;
  logic              rd_en;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] rd_data;

  modport master (output ctrl_we, data_we, rd_en, data_in, input rd_data);
  modport slave  (input ctrl_we, data_we, rd_en, data_in, output rd_data);
endinterface

// File: rtl/pit_read_latch.sv
// Count latch, latch-full flag, read byte pointer and registered read data.
import pit_pkg::*;

module pit_read_latch (
  input  logic              clk,
  input  logic              rst,
  input  logic              latch_cmd,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [1:0]        rw,
  input  logic [CNT_W-1:0]  cnt_current,
  output logic [DATA_W-1:0] rd_data
);

  logic [CNT_W-1:0] latch;
  logic             full;
  logic             msb_next;
  logic             last_byte;

  // A read ends the sequence on single-byte modes or on the MSB half of a two-byte read
  assign last_byte = (rw != RW_BOTH) || msb_next;

  // Serve reads from the pre-edge source; capture/clear the latch on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch    <= '0;
      full     <= 1'b0;
      msb_next <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (rd_en)
        rd_data <= sel_byte(full ? latch : cnt_current, rw, msb_next);
      if (clear) begin
        full     <= 1'b0;
        msb_next <= 1'b0;
      end else begin
        if (rd_en && rw == RW_BOTH)
          msb_next <= ~msb_next;
        if (latch_cmd && !full) begin
          latch <= cnt_current;
          full  <= 1'b1;
        end else if (rd_en && last_byte) begin
          full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pit_channel_ctrl.sv
// Programming/read sequencer for one 8254-style down-counter channel.
import pit_pkg::*;

module pit_channel_ctrl (
  input  logic                     clk,
  input  logic                     rst,
  pit_channel_ctrl_if.slave        bus,
  input  logic                     gate,
  input  logic [CNT_W-1:0]         cnt_current,
  output logic [CNT_W-1:0]         cnt_value,
  output logic                     cnt_load,
  output logic                     cnt_hold,
  output logic [2:0]               mode,
  output logic                     bcd,
  output logic                     null_count
);

  state_t           state;
  logic [1:0]       rw;
  logic [CNT_W-1:0] staging;
  logic             latch_cmd;
  logic             mode_cmd;
  logic             data_wr;

  assign latch_cmd = bus.ctrl_we && (bus.data_in[5:4] == RW_LATCH);
  assign mode_cmd  = bus.ctrl_we && (bus.data_in[5:4] != RW_LATCH);
  // A control word in the same cycle swallows the data byte
  assign data_wr   = bus.data_we && !bus.ctrl_we;

  // The staging register is only meaningful to the counter while cnt_load is high
  assign cnt_value = staging;

  // Control-word decode, count assembly, load pulse and hold generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_UNPROG;
      rw         <= RW_LSB;
      mode       <= 3'd0;
      bcd        <= 1'b0;
      staging    <= '0;
      cnt_load   <= 1'b0;
      cnt_hold   <= 1'b1;
      null_count <= 1'b1;
    end else begin
      cnt_hold <= (state == S_UNPROG) || (state == S_WAIT_MSB) || !gate;
      cnt_load <= 1'b0;
      if (mode_cmd) begin
        rw         <= bus.data_in[5:4];
        mode       <= bus.data_in[3:1];
        bcd        <= bus.data_in[0];
        null_count <= 1'b1;
        state      <= S_UNPROG;
      end else begin
        case (state)
          S_UNPROG, S_RUN: begin
            // In S_RUN the old count keeps going until the new one is loaded
            if (data_wr) begin
              null_count <= 1'b1;
              case (rw)
                RW_LSB: begin
                  staging  <= {8'h00, bus.data_in};
                  cnt_load <= 1'b1;
                  state    <= S_LOAD;
                end
                RW_MSB: begin
                  staging  <= {bus.data_in, 8'h00};
                  cnt_load <= 1'b1;
                  state    <= S_LOAD;
                end
                default: begin
                  staging[7:0] <= bus.data_in;
                  state        <= S_WAIT_MSB;
                end
              endcase
            end
          end
          S_WAIT_MSB: begin
            if (data_wr) begin
              staging[15:8] <= bus.data_in;
              cnt_load      <= 1'b1;
              state         <= S_LOAD;
            end
          end
          default: begin
            null_count <= 1'b0;
            state      <= S_RUN;
          end
        endcase
      end
    end
  end

  pit_read_latch u_read_latch (
    .clk         (clk),
    .rst         (rst),
    .latch_cmd   (latch_cmd),
    .clear       (mode_cmd),
    .rd_en       (bus.rd_en),
    .rw          (rw),
    .cnt_current (cnt_current),
    .rd_data     (bus.rd_data)
  );

endmodule

// File: tb/tb_pit_channel_ctrl.sv
// Directed and random checks of pit_channel_ctrl against a behavioural model.
module tb_pit_channel_ctrl;
  import pit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic [15:0] cnt_current;
  logic [15:0] cnt_value;
  logic        cnt_load, cnt_hold, bcd, null_count;
  logic [2:0]  mode;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pit_channel_ctrl_if bus();

  pit_channel_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gate        (gate),
    .cnt_current (cnt_current),
    .cnt_value   (cnt_value),
    .cnt_load    (cnt_load),
    .cnt_hold    (cnt_hold),
    .mode        (mode),
    .bcd         (bcd),
    .null_count  (null_count)
  );

  // Behavioural model: what the channel has been told and what it owes the bus
  logic [1:0]  m_rw;
  logic [2:0]  m_mode;
  logic        m_bcd, m_null, m_hold, m_load;
  logic        m_running, m_want_msb;
  logic [15:0] m_value, m_latch;
  logic        m_full, m_second;
  logic [7:0]  m_rd;

  task automatic model_reset();
    m_rw = 2'b01; m_mode = 3'd0; m_bcd = 1'b0; m_null = 1'b1; m_hold = 1'b1;
    m_load = 1'b0; m_running = 1'b0; m_want_msb = 1'b0; m_value = 16'h0;
    m_latch = 16'h0; m_full = 1'b0; m_second = 1'b0; m_rd = 8'h0;
  endtask

  task automatic model_edge();
    logic        is_latch, is_mode, wr, last, new_load, hold_n;
    logic [7:0]  d;
    logic [15:0] src;
    d        = bus.data_in;
    is_latch = bus.ctrl_we && d[5:4] == 2'b00;
    is_mode  = bus.ctrl_we && d[5:4] != 2'b00;
    wr       = bus.data_we && !bus.ctrl_we;
    hold_n   = (!m_running && !m_load) || m_want_msb || !gate;
    if (bus.rd_en) begin
      src = m_full ? m_latch : cnt_current;
      if (m_rw == 2'b01)      m_rd = src[7:0];
      else if (m_rw == 2'b10) m_rd = src[15:8];
      else                    m_rd = m_second ? src[15:8] : src[7:0];
    end
    if (is_mode) begin
      m_full = 1'b0; m_second = 1'b0;
    end else begin
      last = bus.rd_en && (m_rw != 2'b11 || m_second);
      if (bus.rd_en && m_rw == 2'b11) m_second = !m_second;
      if (is_latch && !m_full) begin m_full = 1'b1; m_latch = cnt_current; end
      else if (last) m_full = 1'b0;
    end
    new_load = 1'b0;
    if (is_mode) begin
      m_rw = d[5:4]; m_mode = d[3:1]; m_bcd = d[0]; m_null = 1'b1;
      m_running = 1'b0; m_want_msb = 1'b0;
    end else if (m_load) begin
      m_null = 1'b0; m_running = 1'b1;
    end else if (wr) begin
      m_null = 1'b1;
      if (m_want_msb) begin
        m_value[15:8] = d; m_want_msb = 1'b0; new_load = 1'b1;
      end else if (m_rw == 2'b01) begin
        m_value = {8'h00, d}; new_load = 1'b1;
      end else if (m_rw == 2'b10) begin
        m_value = {d, 8'h00}; new_load = 1'b1;
      end else begin
        m_value[7:0] = d; m_want_msb = 1'b1;
      end
    end
    m_load = new_load;
    m_hold = hold_n;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the edge, outputs compared 1ns later, strobes dropped
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_load", cnt_load, m_load);
    if (m_load) chk("m_value", cnt_value, m_value);
    chk("m_hold", cnt_hold, m_hold);
    chk("m_null", null_count, m_null);
    chk("m_mode", mode, m_mode);
    chk("m_bcd", bcd, m_bcd);
    chk("m_rd", bus.rd_data, m_rd);
    bus.ctrl_we = 1'b0; bus.data_we = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic ctrl(input logic [7:0] d);
    bus.ctrl_we = 1'b1; bus.data_in = d; step();
  endtask

  task automatic wr(input logic [7:0] d);
    bus.data_we = 1'b1; bus.data_in = d; step();
  endtask

  task automatic rd();
    bus.rd_en = 1'b1; step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.ctrl_we = 1'b0; bus.data_we = 1'b0; bus.rd_en = 1'b0; bus.data_in = 8'h0;
    gate = 1'b1; cnt_current = 16'h0;
    do_reset();
    chk("rst_hold", cnt_hold, 1'b1);
    chk("rst_null", null_count, 1'b1);
    chk("rst_load", cnt_load, 1'b0);
    chk("rst_value", cnt_value, 16'h0);

    // Two-byte programming
    ctrl(8'h30); wr(8'h34); wr(8'h12);
    chk("t1_load", cnt_load, 1'b1);
    chk("t1_value", cnt_value, 16'h1234);
    chk("t1_null_pend", null_count, 1'b1);
    chk("t1_hold_pend", cnt_hold, 1'b1);
    step();
    chk("t1_load_off", cnt_load, 1'b0);
    chk("t1_null_clr", null_count, 1'b0);
    chk("t1_hold_rel", cnt_hold, 1'b0);

    // Single-byte modes
    ctrl(8'h10); wr(8'hA5);
    chk("t2_lsb", cnt_value, 16'h00A5);
    step();
    ctrl(8'h20); wr(8'h5A);
    chk("t2_msb", cnt_value, 16'h5A00);
    step();

    // Latched read, then a live read once the latch has drained
    ctrl(8'h30);
    cnt_current = 16'hBEEF; ctrl(8'h00);
    cnt_current = 16'h0001;
    rd(); chk("t3_lo", bus.rd_data, 8'hEF);
    rd(); chk("t3_hi", bus.rd_data, 8'hBE);
    rd(); chk("t3_live", bus.rd_data, 8'h01);
    rd();

    // A second latch command while full is ignored
    ctrl(8'h10);
    cnt_current = 16'h1111; ctrl(8'h00);
    cnt_current = 16'h2222; ctrl(8'h00);
    rd(); chk("t4_snap", bus.rd_data, 8'h11);
    rd(); chk("t4_live", bus.rd_data, 8'h22);

    // Control word beats a simultaneous data byte; gate low forces hold
    bus.data_we = 1'b1; ctrl(8'h36);
    chk("t5_mode", mode, 3'd3);
    chk("t5_noload", cnt_load, 1'b0);
    step(); step();
    chk("t5_hold", cnt_hold, 1'b1);
    wr(8'h34); wr(8'h12); step(); step();
    chk("t5_run", cnt_hold, 1'b0);
    gate = 1'b0; step();
    chk("t5_gate", cnt_hold, 1'b1);
    gate = 1'b1; step();

    // Async reset mid-sequence
    ctrl(8'h31); wr(8'h34);
    rst = 1'b1; #1;
    chk("t6_load", cnt_load, 1'b0);
    chk("t6_hold", cnt_hold, 1'b1);
    chk("t6_null", null_count, 1'b1);
    chk("t6_mode", mode, 3'd0);
    chk("t6_bcd", bcd, 1'b0);
    chk("t6_value", cnt_value, 16'h0);
    chk("t6_rd", bus.rd_data, 8'h0);
    @(negedge clk); rst = 1'b0; model_reset();
    // rw is back to LSB-only, so the stray MSB byte becomes a one-byte count
    wr(8'h12);
    chk("t6_single", cnt_value, 16'h0012);
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      gate        = ($urandom_range(0, 7) != 0);
      cnt_current = 16'($urandom);
      bus.data_in = 8'($urandom);
      bus.ctrl_we = ($urandom_range(0, 7) == 0);
      bus.data_we = ($urandom_range(0, 2) == 0);
      bus.rd_en   = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
